// File: rtl/ball_switch_pkg.sv
// Shared definitions for the ball-switch sensor path (debounce and LED stages).
package ball_switch_pkg;

  // Debouncer FSM states: two stable levels, each with a qualifying state
  // that must survive the full window before the clean level flips.
  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_QUAL_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_QUAL_LOW  = 2'd3
  } state_t;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int SYNC_DEFAULT     = 2;

  // Contact levels, shared with the LED stage
  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

endpackage

// File: rtl/sensor_sync.sv
// Flop-chain synchroniser for a single asynchronous contact input.
module sensor_sync #(
  parameter int SYNC_STAGES = ball_switch_pkg::SYNC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw input through SYNC_STAGES flops; the last one is safe to use.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ball_switch_debounce.sv
// Debounces the ball-switch contact into a clean level plus rise/fall event
// pulses and a saturating count of accepted rising events.
module ball_switch_debounce
  import ball_switch_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic             enable,
  input  logic             clear_count,
  output logic             sensor_clean,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] tilt_count,
  output logic             tilt_count_sat
);

  localparam int             QW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [QW-1:0]  CNT_LAST = QW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q;
  state_t        state, state_next;
  logic [QW-1:0] qual_cnt, cnt_next;
  logic          clean_next, rise_next, fall_next;

  sensor_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (sensor_raw),
    .q  (sync_q)
  );

  // Next-state logic: a new level must hold for DEBOUNCE_CYCLES+1 samples
  // with enable high, otherwise the FSM falls back to its stable state.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = qual_cnt;
    clean_next = sensor_clean;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    unique case (state)
      S_LOW: begin
        if (enable && sync_q == HIGH) begin
          state_next = S_QUAL_HIGH;
          cnt_next   = '0;
        end
      end
      S_QUAL_HIGH: begin
        if (sync_q == LOW || !enable) begin
          state_next = S_LOW;
        end else if (qual_cnt == CNT_LAST) begin
          state_next = S_HIGH;
          clean_next = HIGH;
          rise_next  = 1'b1;
        end else begin
          cnt_next = qual_cnt + QW'(1);
        end
      end
      S_HIGH: begin
        if (enable && sync_q == LOW) begin
          state_next = S_QUAL_LOW;
          cnt_next   = '0;
        end
      end
      S_QUAL_LOW: begin
        if (sync_q == HIGH || !enable) begin
          state_next = S_HIGH;
        end else if (qual_cnt == CNT_LAST) begin
          state_next = S_LOW;
          clean_next = LOW;
          fall_next  = 1'b1;
        end else begin
          cnt_next = qual_cnt + QW'(1);
        end
      end
      default: state_next = S_LOW;
    endcase
  end

  // FSM state, qualification counter and registered outputs.
  // NOTE: reset clears only control state and outputs; there is no memory
  // array here that would need (or benefit from) a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_LOW;
      qual_cnt     <= '0;
      sensor_clean <= LOW;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
    end else begin
      state        <= state_next;
      qual_cnt     <= cnt_next;
      sensor_clean <= clean_next;
      rise_pulse   <= rise_next;
      fall_pulse   <= fall_next;
    end
  end

  assign tilt_count_sat = &tilt_count;

  // Saturating rising-event counter; a coincident clear drops the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              tilt_count <= '0;
    else if (clear_count)                 tilt_count <= '0;
    else if (rise_next && !tilt_count_sat) tilt_count <= tilt_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_ball_switch_debounce.sv
// Self-checking bench: directed scenarios plus random contact noise, every
// cycle compared against a run-length model of the debounce rules.
module tb_ball_switch_debounce;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sensor_raw = 1'b0;
  logic          enable = 1'b1;
  logic          clear_count = 1'b0;
  logic          sensor_clean, rise_pulse, fall_pulse, tilt_count_sat;
  logic [CW-1:0] tilt_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: raw samples seen on recent edges, length of the current
  // run of "enabled and different from clean", clean level, pulses, count.
  logic [SYNC-1:0] m_hist;
  int              m_run;
  logic            m_clean, m_rise, m_fall;
  int              m_count;

  ball_switch_debounce #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor_raw    (sensor_raw),
    .enable        (enable),
    .clear_count   (clear_count),
    .sensor_clean  (sensor_clean),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .tilt_count    (tilt_count),
    .tilt_count_sat(tilt_count_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist  = '0;
    m_run   = 0;
    m_clean = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_count = 0;
  endtask

  // One clock edge of the rules: the level seen by the debouncer is the raw
  // value sampled SYNC edges earlier; acceptance needs DEB+1 qualifying samples.
  task automatic model_step();
    logic seen;
    seen   = m_hist[SYNC-1];
    m_hist = {m_hist[SYNC-2:0], sensor_raw};
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (enable && seen != m_clean) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_clean = ~m_clean;
        m_run   = 0;
        if (m_clean) m_rise = 1'b1;
        else         m_fall = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    if (clear_count)                    m_count = 0;
    else if (m_rise && m_count < CMAX)  m_count++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".clean"}, 32'(sensor_clean),   32'(m_clean));
    check({tag, ".rise"},  32'(rise_pulse),     32'(m_rise));
    check({tag, ".fall"},  32'(fall_pulse),     32'(m_fall));
    check({tag, ".count"}, 32'(tilt_count),     32'(m_count));
    check({tag, ".sat"},   32'(tilt_count_sat), 32'(m_count == CMAX));
  endtask

  // Advance one edge, update the model, compare 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_all("cycle");
  endtask

  // Run n edges, collecting pulse counts and the edge index of the first ones.
  task automatic run_ticks(input int n, output int rises, output int falls,
                           output int first_rise, output int first_fall);
    rises = 0; falls = 0; first_rise = 0; first_fall = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (rise_pulse) begin
        rises++;
        if (first_rise == 0) first_rise = i;
      end
      if (fall_pulse) begin
        falls++;
        if (first_fall == 0) first_fall = i;
      end
    end
  endtask

  initial begin
    int r, f, fr, ff;
    int hold;

    // Reset state
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Clean rise: pulse on edge 7, one cycle wide, count 1
    sensor_raw = 1'b1;
    run_ticks(12, r, f, fr, ff);
    check("rise_latency", 32'(fr), 32'd7);
    check("rise_once", 32'(r), 32'd1);
    check("rise_count", 32'(tilt_count), 32'd1);

    // Fall back
    sensor_raw = 1'b0;
    run_ticks(12, r, f, fr, ff);
    check("fall_latency", 32'(ff), 32'd7);

    // 4-cycle glitch is rejected
    sensor_raw = 1'b1;
    run_ticks(4, r, f, fr, ff);
    sensor_raw = 1'b0;
    run_ticks(12, r, f, fr, ff);
    check("glitch4_clean", 32'(sensor_clean), 32'd0);
    check("glitch4_rise", 32'(r + fr), 32'd0);

    // 5-cycle pulse is accepted, then falls 7 edges after raw goes low
    sensor_raw = 1'b1;
    run_ticks(5, r, f, fr, ff);
    sensor_raw = 1'b0;
    run_ticks(12, r, f, fr, ff);
    check("pulse5_rise", 32'(r), 32'd1);
    check("pulse5_fall_latency", 32'(ff), 32'd7);

    // Bounce 1,0,1,1,0,1 then hold 1: one rise, 7 edges after the last 0->1
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int i = 5; i >= 1; i--) begin
        sensor_raw = pat[i];
        tick();
      end
      sensor_raw = pat[0];
      run_ticks(14, r, f, fr, ff);
      check("bounce_rise_once", 32'(r), 32'd1);
      check("bounce_latency", 32'(fr), 32'd7);
    end

    // Enable freeze: clean stays 1 with raw low, then falls after re-enable
    enable     = 1'b0;
    sensor_raw = 1'b0;
    run_ticks(20, r, f, fr, ff);
    check("freeze_clean", 32'(sensor_clean), 32'd1);
    check("freeze_nofall", 32'(f), 32'd0);
    enable = 1'b1;
    run_ticks(10, r, f, fr, ff);
    check("unfreeze_fall", 32'(f), 32'd1);

    // Async reset mid-qualification, release with raw high
    sensor_raw = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    for (int i = 0; i < 2; i++) tick();
    #2;
    rst = 1'b0;
    run_ticks(12, r, f, fr, ff);
    check("post_reset_rise", 32'(r), 32'd1);

    // Saturation: 16 further rises, count must stop at all-ones
    for (int k = 0; k < 16; k++) begin
      sensor_raw = 1'b0;
      run_ticks(8, r, f, fr, ff);
      sensor_raw = 1'b1;
      run_ticks(8, r, f, fr, ff);
    end
    check("sat_count", 32'(tilt_count), 32'(CMAX));
    check("sat_flag", 32'(tilt_count_sat), 32'd1);

    // Clear coincident with a rise: clear wins
    sensor_raw = 1'b0;
    run_ticks(10, r, f, fr, ff);
    sensor_raw = 1'b1;
    run_ticks(6, r, f, fr, ff);
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("clear_rise", 32'(rise_pulse), 32'd1);
    check("clear_wins", 32'(tilt_count), 32'd0);

    // Random contact noise with occasional enable drops and clears
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        sensor_raw = 1'($urandom_range(0, 1));
        hold       = $urandom_range(1, 9);
      end
      hold--;
      enable      = ($urandom_range(0, 9) != 0);
      clear_count = ($urandom_range(0, 29) == 0);
      tick();
      check("no_dual_pulse", 32'(rise_pulse & fall_pulse), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
